rtc_bus_scheduler: RTL and testbench

//  Sole owner of the multiplexed 8-bit RTC bus (address/data on one bus). Runs

---
 rtl/rtc_sched_pkg.sv | 88 ++++++++
 rtl/rtc_bus_scheduler_refresh_tick.sv | 33 +++
 rtl/rtc_bus_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_rtc_bus_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_sched_pkg.sv
// Shared types and constants for the RTC bus scheduler: FSM states, bus drive
// payload, and the register address table swept for the display.
package rtc_sched_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned NREG   = 9;
    localparam int unsigned SLOT_W = 4;

    localparam int unsigned REG_SEC  = 0;
    localparam int unsigned REG_MIN  = 1;
    localparam int unsigned REG_HR   = 2;
    localparam int unsigned REG_DAY  = 3;
    localparam int unsigned REG_MON  = 4;
    localparam int unsigned REG_YR   = 5;
    localparam int unsigned REG_TSEC = 6;
    localparam int unsigned REG_TMIN = 7;
    localparam int unsigned REG_THR  = 8;

    typedef enum logic [2:0] {
        ST_ARB,
        ST_ADDR_LO,
        ST_ADDR_HI,
        ST_DATA_LO,
        ST_DATA_HI
    } state_t;

    typedef struct packed {
        logic              cs_n;
        logic              ad_n;
        logic              wr_n;
        logic              rd_n;
        logic              oe;
        logic [BYTE_W-1:0] dout;
    } bus_t;

    localparam bus_t BUS_IDLE = '{cs_n: 1'b1, ad_n: 1'b1, wr_n: 1'b1, rd_n: 1'b1,
                                  oe: 1'b0, dout: '0};

    // RTC register address for each sweep slot.
    function automatic logic [BYTE_W-1:0] reg_addr(input logic [SLOT_W-1:0] slot);
        logic [BYTE_W-1:0] a;
        case (slot)
            SLOT_W'(REG_SEC):  a = 8'h21;
            SLOT_W'(REG_MIN):  a = 8'h22;
            SLOT_W'(REG_HR):   a = 8'h23;
            SLOT_W'(REG_DAY):  a = 8'h24;
            SLOT_W'(REG_MON):  a = 8'h25;
            SLOT_W'(REG_YR):   a = 8'h26;
            SLOT_W'(REG_TSEC): a = 8'h41;
            SLOT_W'(REG_TMIN): a = 8'h42;
            SLOT_W'(REG_THR):  a = 8'h43;
            default:           a = 8'h21;
        endcase
        return a;
    endfunction

    // Pin levels to present while in a given transaction state.
    function automatic bus_t bus_for(input state_t            st,
                                     input logic              is_wr,
                                     input logic [BYTE_W-1:0] addr,
                                     input logic [BYTE_W-1:0] data);
        bus_t b;
        b = BUS_IDLE;
        case (st)
            ST_ADDR_LO, ST_ADDR_HI: begin
                b.cs_n = 1'b0;
                b.ad_n = 1'b0;
                b.wr_n = (st == ST_ADDR_HI);
                b.oe   = 1'b1;
                b.dout = addr;
            end
            ST_DATA_LO: begin
                b.cs_n = 1'b0;
                if (is_wr) begin
                    b.wr_n = 1'b0;
                    b.oe   = 1'b1;
                    b.dout = data;
                end else begin
                    b.rd_n = 1'b0;
                end
            end
            ST_DATA_HI: b.cs_n = 1'b0;
            default:    b = BUS_IDLE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rtc_bus_scheduler_refresh_tick.sv
// Free-running refresh counter; o_tick is high for the one cycle in which the
// counter sits at REFRESH_CYCLES-1 (just before it wraps to 0).
module rtc_refresh_tick #(
    parameter int unsigned REFRESH_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    output logic o_tick
);

    localparam int unsigned CNT_W = $clog2(REFRESH_CYCLES);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;

    // Tick is registered one count early so it lines up with the wrap cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_cnt == CNT_W'(REFRESH_CYCLES - 2));
            if (r_cnt == CNT_W'(REFRESH_CYCLES - 1)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/rtc_bus_scheduler.sv
// Sole owner of the multiplexed RTC bus: periodic read sweeps plus write-first
// edit writes. Optional RTC_SCHED_FREEZE_EN holds off new sweeps during edit.
module rtc_bus_scheduler
    import rtc_sched_pkg::*;
#(
    parameter int unsigned PHASE_CYCLES   = 4,
    parameter int unsigned REFRESH_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_req,
    input  logic [BYTE_W-1:0] wr_addr,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              edit_active,
    output logic              wr_ack,
    output logic              rd_valid,
    output logic [SLOT_W-1:0] rd_idx,
    output logic [BYTE_W-1:0] rd_data,
    output logic              busy,
    output logic              rtc_cs_n,
    output logic              rtc_ad_n,
    output logic              rtc_wr_n,
    output logic              rtc_rd_n,
    output logic [BYTE_W-1:0] ad_out,
    output logic              ad_oe,
    input  logic [BYTE_W-1:0] ad_in
);

    localparam int unsigned PH_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;

    state_t            r_state;
    logic [PH_W-1:0]   r_phase;
    logic              r_is_wr;
    logic [BYTE_W-1:0] r_addr;
    logic [BYTE_W-1:0] r_data;
    logic [BYTE_W-1:0] r_sample;
    logic [SLOT_W-1:0] r_slot;
    logic              r_active;
    logic              r_pending;
    bus_t              r_bus;
    logic              r_wr_ack;
    logic              r_rd_valid;
    logic [SLOT_W-1:0] r_rd_idx;
    logic [BYTE_W-1:0] r_rd_data;

    logic w_tick;
    logic w_phase_last;
    logic w_new_ok;
    logic w_rd_go;

    rtc_refresh_tick #(
        .REFRESH_CYCLES(REFRESH_CYCLES)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .o_tick(w_tick)
    );

`ifdef RTC_SCHED_FREEZE_EN
    assign w_new_ok = ~edit_active;
`else
    logic w_unused_edit;
    assign w_unused_edit = edit_active;
    assign w_new_ok      = 1'b1;
`endif

    // A running sweep always continues; only the start of a new one can be held.
    assign w_rd_go      = r_active | (r_pending & w_new_ok);
    assign w_phase_last = (r_phase == PH_W'(PHASE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_ARB;
            r_phase    <= '0;
            r_is_wr    <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_sample   <= '0;
            r_slot     <= '0;
            r_active   <= 1'b0;
            r_pending  <= 1'b0;
            r_bus      <= BUS_IDLE;
            r_wr_ack   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_idx   <= '0;
            r_rd_data  <= '0;
        end else begin
            r_wr_ack   <= 1'b0;
            r_rd_valid <= 1'b0;
            if (w_tick) begin
                r_pending <= 1'b1;
            end

            if (r_state != ST_ARB) begin
                r_phase <= w_phase_last ? '0 : r_phase + PH_W'(1);
            end

            case (r_state)
                ST_ARB: begin
                    r_phase <= '0;
                    if (wr_req) begin
                        r_is_wr <= 1'b1;
                        r_addr  <= wr_addr;
                        r_data  <= wr_data;
                        r_state <= ST_ADDR_LO;
                        r_bus   <= bus_for(ST_ADDR_LO, 1'b1, wr_addr, wr_data);
                    end else if (w_rd_go) begin
                        r_is_wr <= 1'b0;
                        r_addr  <= reg_addr(r_slot);
                        r_state <= ST_ADDR_LO;
                        r_bus   <= bus_for(ST_ADDR_LO, 1'b0, reg_addr(r_slot), '0);
                        // Starting a sweep consumes the pending flag; a tick in
                        // this very cycle re-arms it for the following sweep.
                        if (!r_active) begin
                            r_active  <= 1'b1;
                            r_pending <= w_tick;
                        end
                    end
                end

                ST_ADDR_LO: begin
                    if (w_phase_last) begin
                        r_state <= ST_ADDR_HI;
                        r_bus   <= bus_for(ST_ADDR_HI, r_is_wr, r_addr, r_data);
                    end
                end

                ST_ADDR_HI: begin
                    if (w_phase_last) begin
                        r_state <= ST_DATA_LO;
                        r_bus   <= bus_for(ST_DATA_LO, r_is_wr, r_addr, r_data);
                    end
                end

                ST_DATA_LO: begin
                    if (w_phase_last) begin
                        if (!r_is_wr) begin
                            r_sample <= ad_in;
                        end
                        r_state <= ST_DATA_HI;
                        r_bus   <= bus_for(ST_DATA_HI, r_is_wr, r_addr, r_data);
                    end
                end

                ST_DATA_HI: begin
                    if (w_phase_last) begin
                        r_state <= ST_ARB;
                        r_bus   <= BUS_IDLE;
                        if (r_is_wr) begin
                            r_wr_ack <= 1'b1;
                        end else begin
                            r_rd_valid <= 1'b1;
                            r_rd_idx   <= r_slot;
                            r_rd_data  <= r_sample;
                            if (r_slot == SLOT_W'(NREG - 1)) begin
                                r_slot   <= '0;
                                r_active <= 1'b0;
                            end else begin
                                r_slot <= r_slot + SLOT_W'(1);
                            end
                        end
                    end
                end

                default: begin
                    r_state <= ST_ARB;
                    r_bus   <= BUS_IDLE;
                end
            endcase
        end
    end

    // Busy covers the grant cycle itself, hence the ARB-cycle request terms.
    assign busy     = (r_state != ST_ARB) | wr_req | w_rd_go;

    assign wr_ack   = r_wr_ack;
    assign rd_valid = r_rd_valid;
    assign rd_idx   = r_rd_idx;
    assign rd_data  = r_rd_data;
    assign rtc_cs_n = r_bus.cs_n;
    assign rtc_ad_n = r_bus.ad_n;
    assign rtc_wr_n = r_bus.wr_n;
    assign rtc_rd_n = r_bus.rd_n;
    assign ad_oe    = r_bus.oe;
    assign ad_out   = r_bus.dout;

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Directed bench for rtc_bus_scheduler (PHASE_CYCLES=2, REFRESH_CYCLES=100)
// with a small RTC pin model that answers reads from the latched address.
module tb_rtc_bus_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_req = 1'b0;
    logic [7:0] wr_addr = 8'h00;
    logic [7:0] wr_data = 8'h00;
    logic       edit_active = 1'b0;
    logic       wr_ack, rd_valid, busy;
    logic [3:0] rd_idx;
    logic [7:0] rd_data, ad_out, ad_in;
    logic       rtc_cs_n, rtc_ad_n, rtc_wr_n, rtc_rd_n, ad_oe;

    rtc_bus_scheduler #(.PHASE_CYCLES(2), .REFRESH_CYCLES(100)) dut (
        .clk(clk), .reset(reset), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .edit_active(edit_active), .wr_ack(wr_ack), .rd_valid(rd_valid), .rd_idx(rd_idx),
        .rd_data(rd_data), .busy(busy), .rtc_cs_n(rtc_cs_n), .rtc_ad_n(rtc_ad_n),
        .rtc_wr_n(rtc_wr_n), .rtc_rd_n(rtc_rd_n), .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int base = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / RTC model state (written only by the monitor process).
    int         ev_q[$];
    int         ev_t[$];
    logic [7:0] addr_q[$];
    logic [7:0] rdd_q[$];
    int         ack_cnt = 0;
    int         oe_viol = 0;
    logic       prev_alo = 1'b0;
    logic [7:0] lat_addr = 8'h00;
    logic [7:0] wr_cap = 8'h00;

    logic [7:0] exp_addr [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};

    assign ad_in = (lat_addr == 8'h23) ? 8'hA5 : ~lat_addr;

    always @(negedge clk) begin
        if (reset) begin
            prev_alo = 1'b0;
        end else begin
            if (rd_valid) begin
                ev_q.push_back(int'(rd_idx));
                ev_t.push_back(cyc - base);
                rdd_q.push_back(rd_data);
            end
            if (wr_ack) begin
                ev_q.push_back(100);
                ev_t.push_back(cyc - base);
                ack_cnt++;
            end
            if (!rtc_cs_n && !rtc_ad_n && !rtc_wr_n && !prev_alo) addr_q.push_back(ad_out);
            prev_alo = !rtc_cs_n && !rtc_ad_n && !rtc_wr_n;
            if (!rtc_cs_n && !rtc_ad_n) lat_addr = ad_out;
            if (!rtc_cs_n && rtc_ad_n && !rtc_wr_n) wr_cap = ad_out;
            if (!rtc_cs_n && rtc_ad_n && rtc_wr_n && ad_oe) oe_viol++;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        wr_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        base = cyc;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rtc_cs_n, rtc_ad_n, rtc_wr_n, rtc_rd_n, ad_oe} !== 5'b11110) begin
            errors++;
            $display("FAIL reset_pins got=%b exp=11110", {rtc_cs_n, rtc_ad_n, rtc_wr_n, rtc_rd_n, ad_oe});
        end
        checks++;
        if ({wr_ack, rd_valid, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_pulses got=%b exp=000", {wr_ack, rd_valid, busy});
        end
        checks++;
        if ({ad_out, rd_data, rd_idx} !== 20'h0) begin
            errors++;
            $display("FAIL reset_data got=%h exp=00000", {ad_out, rd_data, rd_idx});
        end
    endtask

    task automatic test_sweep();
        int s0, a0, r0, ov0;
        do_reset();
        s0 = ev_q.size(); a0 = addr_q.size(); r0 = rdd_q.size(); ov0 = oe_viol;
        for (int k = 0; k < 260; k++) begin
            @(negedge clk);
            if (ev_q.size() >= s0 + 9) break;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (ev_q.size() - s0 != 9 || addr_q.size() - a0 < 9) begin
            errors++;
            $display("FAIL sweep_count got=%0d exp=9", ev_q.size() - s0);
            return;
        end
        checks++;
        if (ev_t[s0] != 109) begin
            errors++;
            $display("FAIL sweep_first_time got=%0d exp=109", ev_t[s0]);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (ev_q[s0 + i] != i) begin
                errors++;
                $display("FAIL sweep_idx[%0d] got=%0d exp=%0d", i, ev_q[s0 + i], i);
            end
            checks++;
            if (addr_q[a0 + i] !== exp_addr[i]) begin
                errors++;
                $display("FAIL sweep_addr[%0d] got=%h exp=%h", i, addr_q[a0 + i], exp_addr[i]);
            end
            if (i > 0) begin
                checks++;
                if (ev_t[s0 + i] - ev_t[s0 + i - 1] != 9) begin
                    errors++;
                    $display("FAIL sweep_gap[%0d] got=%0d exp=9", i, ev_t[s0 + i] - ev_t[s0 + i - 1]);
                end
            end
        end
        checks++;
        if (rdd_q[r0 + 2] !== 8'hA5) begin
            errors++;
            $display("FAIL rd_data_slot2 got=%h exp=a5", rdd_q[r0 + 2]);
        end
        checks++;
        if (rdd_q[r0] !== 8'hDE || rdd_q[r0 + 8] !== 8'hBC) begin
            errors++;
            $display("FAIL rd_data_ends got=%h/%h exp=de/bc", rdd_q[r0], rdd_q[r0 + 8]);
        end
        checks++;
        if (oe_viol != ov0) begin
            errors++;
            $display("FAIL read_oe got=%0d driven cycles exp=0", oe_viol - ov0);
        end
    endtask

    task automatic test_write_idle();
        int t0, a0;
        logic got;
        do_reset();
        repeat (5) @(negedge clk);
        a0 = ack_cnt;
        wr_req = 1'b1; wr_addr = 8'h21; wr_data = 8'h59; t0 = cyc;
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy_grant got=%b exp=1", busy); end
        @(negedge clk);
        checks++;
        if ({rtc_cs_n, rtc_ad_n, rtc_wr_n, rtc_rd_n, ad_oe} !== 5'b00011 || ad_out !== 8'h21) begin
            errors++;
            $display("FAIL wr_addr_lo got=%b/%h exp=00011/21", {rtc_cs_n, rtc_ad_n, rtc_wr_n, rtc_rd_n, ad_oe}, ad_out);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({rtc_cs_n, rtc_ad_n, rtc_wr_n, rtc_rd_n, ad_oe} !== 5'b00111) begin
            errors++;
            $display("FAIL wr_addr_hi got=%b exp=00111", {rtc_cs_n, rtc_ad_n, rtc_wr_n, rtc_rd_n, ad_oe});
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({rtc_cs_n, rtc_ad_n, rtc_wr_n, rtc_rd_n, ad_oe} !== 5'b01011 || ad_out !== 8'h59) begin
            errors++;
            $display("FAIL wr_data_lo got=%b/%h exp=01011/59", {rtc_cs_n, rtc_ad_n, rtc_wr_n, rtc_rd_n, ad_oe}, ad_out);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({rtc_cs_n, rtc_ad_n, rtc_wr_n, rtc_rd_n, ad_oe} !== 5'b01110) begin
            errors++;
            $display("FAIL wr_data_hi got=%b exp=01110", {rtc_cs_n, rtc_ad_n, rtc_wr_n, rtc_rd_n, ad_oe});
        end
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (wr_ack) begin got = 1'b1; break; end
        end
        wr_req = 1'b0;
        checks++;
        if (!got || cyc - t0 != 9) begin
            errors++;
            $display("FAIL wr_ack_latency got=%0d seen=%b exp=9", cyc - t0, got);
        end
        repeat (12) @(negedge clk);
        checks++;
        if (ack_cnt - a0 != 1) begin errors++; $display("FAIL wr_ack_count got=%0d exp=1", ack_cnt - a0); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_idle got=%b exp=0", busy); end
    endtask

    task automatic test_write_mid_sweep();
        int s0;
        logic got;
        int exp_seq [10] = '{0, 1, 2, 3, 100, 4, 5, 6, 7, 8};
        do_reset();
        s0 = ev_q.size();
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rd_valid && rd_idx == 4'd2) begin got = 1'b1; break; end
        end
        repeat (3) @(negedge clk);
        wr_req = 1'b1; wr_addr = 8'h25; wr_data = 8'h12;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (wr_ack) break;
        end
        wr_req = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ev_q.size() >= s0 + 10) break;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (!got || ev_q.size() - s0 != 10) begin
            errors++;
            $display("FAIL mid_count got=%0d slot2_seen=%b exp=10", ev_q.size() - s0, got);
            return;
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (ev_q[s0 + i] != exp_seq[i]) begin
                errors++;
                $display("FAIL mid_seq[%0d] got=%0d exp=%0d", i, ev_q[s0 + i], exp_seq[i]);
            end
        end
        checks++;
        if (ev_t[s0 + 4] - ev_t[s0 + 3] != 9 || ev_t[s0 + 5] - ev_t[s0 + 4] != 9) begin
            errors++;
            $display("FAIL mid_timing got=%0d/%0d exp=9/9", ev_t[s0 + 4] - ev_t[s0 + 3], ev_t[s0 + 5] - ev_t[s0 + 4]);
        end
        checks++;
        if (wr_cap !== 8'h12) begin errors++; $display("FAIL mid_wr_data got=%h exp=12", wr_cap); end
    endtask

    task automatic test_reset_mid_write();
        int a0, s0;
        do_reset();
        repeat (5) @(negedge clk);
        wr_req = 1'b1; wr_addr = 8'h22; wr_data = 8'h33;
        repeat (5) @(negedge clk);
        checks++;
        if ({rtc_ad_n, rtc_wr_n, ad_oe} !== 3'b101) begin
            errors++;
            $display("FAIL rst_mid_in_data_lo got=%b exp=101", {rtc_ad_n, rtc_wr_n, ad_oe});
        end
        reset = 1'b1;
        wr_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({rtc_cs_n, rtc_ad_n, rtc_wr_n, rtc_rd_n, ad_oe} !== 5'b11110) begin
            errors++;
            $display("FAIL rst_mid_pins got=%b exp=11110", {rtc_cs_n, rtc_ad_n, rtc_wr_n, rtc_rd_n, ad_oe});
        end
        reset = 1'b0;
        base = cyc;
        a0 = ack_cnt;
        s0 = ev_q.size();
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (ev_q.size() > s0) break;
        end
        #1;
        checks++;
        if (ack_cnt != a0) begin errors++; $display("FAIL rst_mid_no_ack got=%0d exp=0", ack_cnt - a0); end
        checks++;
        if (ev_q.size() <= s0 || ev_q[s0] != 0 || ev_t[s0] != 109) begin
            errors++;
            $display("FAIL rst_mid_next_sweep got_events=%0d exp=first slot 0 at cycle 109", ev_q.size() - s0);
        end
    endtask

    task automatic test_edit_active();
        int s0;
        do_reset();
        edit_active = 1'b1;
        s0 = ev_q.size();
`ifdef RTC_SCHED_FREEZE_EN
        repeat (150) @(negedge clk);
        checks++;
        if (ev_q.size() != s0) begin
            errors++;
            $display("FAIL freeze_held got=%0d events exp=0", ev_q.size() - s0);
        end
        edit_active = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ev_q.size() > s0) break;
        end
        #1;
        checks++;
        if (ev_q.size() <= s0 || ev_q[s0] != 0 || ev_t[s0] != 159) begin
            errors++;
            $display("FAIL freeze_release got_events=%0d exp=slot 0 at cycle 159", ev_q.size() - s0);
        end
`else
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (ev_q.size() > s0) break;
        end
        #1;
        checks++;
        if (ev_q.size() <= s0 || ev_q[s0] != 0 || ev_t[s0] != 109) begin
            errors++;
            $display("FAIL edit_ignored got_events=%0d exp=slot 0 at cycle 109", ev_q.size() - s0);
        end
`endif
        edit_active = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_write_idle();
        test_write_mid_sweep();
        test_reset_mid_write();
        test_edit_active();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
